// File: rtl/chu_sseg_core.sv
// Eight-digit, active-low seven-segment display MMIO slot core.
// Digits are time-multiplexed by a free-running scan counter (slice/phase/digit/frame)
// and dimmed with a 16-level PWM gated by the phase counter.
// Optional hex decoding of digit bytes is enabled by defining SSEG_HEX_DECODE_EN.
module chu_sseg_core #(
  parameter int unsigned DIGIT_TICKS = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic [7:0]  sseg,
  output logic [7:0]  an
);

  localparam int unsigned SliceTicks = DIGIT_TICKS / 16;
  localparam int unsigned SliceW     = (SliceTicks > 1) ? $clog2(SliceTicks) : 1;
  localparam logic [SliceW-1:0] SliceMax = SliceW'(SliceTicks - 1);

  // Register file
  logic [31:0] data_lo_q, data_hi_q;
  logic [7:0]  mask_q;
  logic [3:0]  bright_q;
  logic        hex_en;

  // Scan counters
  logic [SliceW-1:0] slice_q, slice_d;
  logic [3:0]        phase_q, phase_d;
  logic [2:0]        digit_q, digit_d;
  logic [15:0]       frame_q, frame_d;

  logic [7:0] an_d, sseg_d;
  logic       wr_en;
  logic       unused_bits;

  assign wr_en       = cs & write;
  // Strobe and non-register write bits carry no function here.
  assign unused_bits = ^{read, wr_data};

`ifdef SSEG_HEX_DECODE_EN
  logic hex_q;
  assign hex_en = hex_q;

  // Hex digit to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] v);
    unique case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction
`else
  assign hex_en = 1'b0;
`endif

  // Register writes; CTRL fields are split into their own flops
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_lo_q <= 32'hFFFF_FFFF;
      data_hi_q <= 32'hFFFF_FFFF;
      mask_q    <= 8'hFF;
      bright_q  <= 4'hF;
`ifdef SSEG_HEX_DECODE_EN
      hex_q     <= 1'b0;
`endif
    end else if (wr_en) begin
      case (addr)
        5'd0: data_lo_q <= wr_data;
        5'd1: data_hi_q <= wr_data;
        5'd2: begin
          mask_q   <= wr_data[7:0];
          bright_q <= wr_data[11:8];
`ifdef SSEG_HEX_DECODE_EN
          hex_q    <= wr_data[16];
`endif
        end
        default: ;
      endcase
    end
  end

  // Combinational read mux; reads have no side effects
  always_comb begin
    rd_data = 32'h0;
    case (addr)
      5'd0: rd_data = data_lo_q;
      5'd1: rd_data = data_hi_q;
      5'd2: rd_data = {15'h0, hex_en, 4'h0, bright_q, mask_q};
      5'd3: rd_data = {frame_q, 13'h0, digit_q};
      default: rd_data = 32'h0;
    endcase
  end

  // Scan counter next state: slice -> phase -> digit -> frame carry chain
  always_comb begin
    slice_d = slice_q + 1'b1;
    phase_d = phase_q;
    digit_d = digit_q;
    frame_d = frame_q;
    if (slice_q == SliceMax) begin
      slice_d = '0;
      phase_d = phase_q + 4'd1;
      if (phase_q == 4'hF) begin
        digit_d = digit_q + 3'd1;
        if (digit_q == 3'd7) frame_d = frame_q + 16'd1;
      end
    end
  end

  // Scan counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      slice_q <= '0;
      phase_q <= '0;
      digit_q <= '0;
      frame_q <= '0;
    end else begin
      slice_q <= slice_d;
      phase_q <= phase_d;
      digit_q <= digit_d;
      frame_q <= frame_d;
    end
  end

  // Output select: current digit lit only while enabled and within the PWM on-window
  always_comb begin
    logic [63:0] all_data;
    logic [7:0]  pat;
    all_data = {data_hi_q, data_lo_q};
    pat      = all_data[{digit_q, 3'b000} +: 8];
    an_d     = 8'hFF;
    sseg_d   = 8'hFF;
    if (mask_q[digit_q] && (phase_q <= bright_q)) begin
      an_d   = ~(8'h01 << digit_q);
      sseg_d = pat;
`ifdef SSEG_HEX_DECODE_EN
      if (hex_en) sseg_d = {~pat[7], hex7(pat[3:0])};
`endif
    end
  end

  // Output register; an and sseg always update on the same edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      an   <= 8'hFF;
      sseg <= 8'hFF;
    end else begin
      an   <= an_d;
      sseg <= sseg_d;
    end
  end

endmodule

// File: tb/tb_chu_sseg_core.sv
// Directed testbench for chu_sseg_core with DIGIT_TICKS = 32.
// A cycle count since reset release drives a small timing model of the scan.
module tb_chu_sseg_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [7:0]  sseg, an;

  int ncmp = 0;
  int nmis = 0;
  int cyc  = 0;

  // Shadow of the software-visible registers
  logic [31:0] sh_lo, sh_hi;
  logic [7:0]  sh_mask;
  logic [3:0]  sh_b;
  logic        sh_hex;

  chu_sseg_core #(.DIGIT_TICKS(32)) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .sseg(sseg), .an(an)
  );

  always #5 clk = ~clk;

  // Edges seen with reset high since the last reset
  always @(posedge clk) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[v];
  endfunction

  // Expected outputs after t edges out of reset
  function automatic void model(input int t, output logic [7:0] ea, output logic [7:0] es);
    int u, d, p;
    logic [63:0] all;
    logic [7:0]  pat;
    ea = 8'hFF;
    es = 8'hFF;
    if (t > 0) begin
      u   = t - 1;
      d   = (u / 32) % 8;
      p   = (u % 32) / 2;
      all = {sh_hi, sh_lo};
      pat = all[d*8 +: 8];
      if (sh_mask[d] && p <= int'(sh_b)) begin
        ea = ~(8'h01 << d);
        es = sh_hex ? {~pat[7], hex7(pat[3:0])} : pat;
      end
    end
  endfunction

  function automatic logic [31:0] exp_status(input int t);
    logic [15:0] f;
    logic [2:0]  d;
    f = 16'((t / 256) % 65536);
    d = 3'((t / 32) % 8);
    return {f, 13'h0, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shadow_reset();
    sh_lo = 32'hFFFF_FFFF; sh_hi = 32'hFFFF_FFFF;
    sh_mask = 8'hFF; sh_b = 4'hF; sh_hex = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    step();
    cs = 1'b0; write = 1'b0;
    case (a)
      5'd0: sh_lo = d;
      5'd1: sh_hi = d;
      5'd2: begin
        sh_mask = d[7:0];
        sh_b    = d[11:8];
`ifdef SSEG_HEX_DECODE_EN
        sh_hex  = d[16];
`endif
      end
      default: ;
    endcase
  endtask

  task automatic test_reset();
    logic [31:0] exp_rd [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0FFF, 32'h0};
    reset = 1'b0;
    shadow_reset();
    repeat (3) step();
    ncmp++;
    if (an !== 8'hFF) begin nmis++; $display("FAIL reset_an got %h want ff", an); end
    ncmp++;
    if (sseg !== 8'hFF) begin nmis++; $display("FAIL reset_sseg got %h want ff", sseg); end
    for (int i = 0; i < 4; i++) begin
      addr = 5'(i);
      #1;
      ncmp++;
      if (rd_data !== exp_rd[i]) begin
        nmis++; $display("FAIL reset_rd addr=%0d got %h want %h", i, rd_data, exp_rd[i]);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_data();
    logic [7:0] ea, es;
    wr(5'd0, 32'hC0F9_A4B0);
    addr = 5'd0;
    #1;
    ncmp++;
    if (rd_data !== 32'hC0F9_A4B0) begin
      nmis++; $display("FAIL data_rd got %h want c0f9a4b0", rd_data);
    end
    for (int i = 0; i < 256; i++) begin
      step();
      model(cyc, ea, es);
      ncmp++;
      if (an !== ea || sseg !== es) begin
        nmis++; $display("FAIL data_scan t=%0d got an=%h sseg=%h want an=%h sseg=%h",
                         cyc, an, sseg, ea, es);
      end
    end
  endtask

  task automatic test_brightness();
    logic [7:0] ea, es;
    int lit = 0;
    wr(5'd2, 32'h0000_03FF);
    for (int i = 0; i < 256; i++) begin
      step();
      model(cyc, ea, es);
      if (an !== 8'hFF) lit++;
      ncmp++;
      if (an !== ea || sseg !== es) begin
        nmis++; $display("FAIL bright_scan t=%0d got an=%h sseg=%h want an=%h sseg=%h",
                         cyc, an, sseg, ea, es);
      end
    end
    ncmp++;
    if (lit !== 64) begin nmis++; $display("FAIL bright_duty got %0d want 64", lit); end
  endtask

  task automatic test_mask_frame();
    logic [7:0]  ea, es;
    logic [31:0] st;
    int lit = 0;
    wr(5'd2, 32'h0000_0F05);
    addr = 5'd3;
    for (int i = 0; i < 512; i++) begin
      step();
      model(cyc, ea, es);
      if (an !== 8'hFF) lit++;
      ncmp++;
      if (an !== ea || sseg !== es || !(an inside {8'hFF, 8'hFE, 8'hFB})) begin
        nmis++; $display("FAIL mask_scan t=%0d got an=%h sseg=%h want an=%h sseg=%h",
                         cyc, an, sseg, ea, es);
      end
      if (i % 32 == 7) begin
        st = exp_status(cyc);
        ncmp++;
        if (rd_data !== st) begin
          nmis++; $display("FAIL status t=%0d got %h want %h", cyc, rd_data, st);
        end
      end
    end
    ncmp++;
    if (lit !== 128) begin nmis++; $display("FAIL mask_lit got %0d want 128", lit); end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    while (!((cyc / 32) % 8 == 5 && cyc % 32 == 10) && guard < 300) begin
      step();
      guard++;
    end
    ncmp++;
    if (guard >= 300) begin nmis++; $display("FAIL midreset_align got %0d want <300", guard); end
    reset = 1'b0;
    step();
    shadow_reset();
    addr = 5'd3;
    #1;
    ncmp++;
    if (an !== 8'hFF || sseg !== 8'hFF) begin
      nmis++; $display("FAIL midreset_blank got an=%h sseg=%h want ff ff", an, sseg);
    end
    ncmp++;
    if (rd_data !== 32'h0) begin
      nmis++; $display("FAIL midreset_status got %h want 0", rd_data);
    end
    reset = 1'b1;
    step();
    ncmp++;
    if (an !== 8'hFE || sseg !== 8'hFF) begin
      nmis++; $display("FAIL midreset_first got an=%h sseg=%h want fe ff", an, sseg);
    end
    // Clear the whole mask while digit 0 is lit
    wr(5'd2, 32'h0000_0F00);
    ncmp++;
    if (an !== 8'hFE) begin nmis++; $display("FAIL maskclr_old got %h want fe", an); end
    step();
    ncmp++;
    if (an !== 8'hFF) begin nmis++; $display("FAIL maskclr_new got %h want ff", an); end
  endtask

  task automatic test_hex();
    logic [7:0] ea, es;
    logic [31:0] want_ctrl;
    logic [7:0]  want_sseg;
    int guard = 0;
`ifdef SSEG_HEX_DECODE_EN
    want_ctrl = 32'h0001_0FFF;
    want_sseg = 8'h08;
`else
    want_ctrl = 32'h0000_0FFF;
    want_sseg = 8'h8A;
`endif
    wr(5'd2, 32'h0001_0FFF);
    wr(5'd0, 32'h0000_008A);
    addr = 5'd2;
    #1;
    ncmp++;
    if (rd_data !== want_ctrl) begin
      nmis++; $display("FAIL hex_ctrl got %h want %h", rd_data, want_ctrl);
    end
    step();
    while (an !== 8'hFE && guard < 300) begin
      step();
      guard++;
    end
    model(cyc, ea, es);
    ncmp++;
    if (an !== 8'hFE || sseg !== want_sseg || es !== want_sseg) begin
      nmis++; $display("FAIL hex_sseg got an=%h sseg=%h want fe %h", an, sseg, want_sseg);
    end
  endtask

  initial begin
    reset = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
    test_reset();
    test_data();
    test_brightness();
    test_mask_frame();
    test_reset_mid();
    test_hex();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
